// File: rtl/channel_arbiter_16_pkg.sv
// Shared types and constants for the 16-channel round-robin arbiter.
// Holds the FSM encoding, channel count, select width and grant reset value.
package channel_arbiter_16_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam int NUM_CH = 16;
   localparam int SEL_W  = 8;

   // Channel 0 has first priority after reset.
   localparam logic [3:0] LAST_GRANT_RST = 4'd15;

endpackage

// File: rtl/channel_arbiter_16_mux16.sv
// mux16: 16-to-1 data multiplexer.
// Ports: data_i (16*WIDTH), sel_i (4) -> data_o (WIDTH).
module mux16 #(
   parameter int WIDTH = 16
) (
   input  logic [16*WIDTH-1:0] data_i,
   input  logic [3:0]          sel_i,
   output logic [WIDTH-1:0]    data_o
);

   assign data_o = data_i[sel_i*WIDTH +: WIDTH];

endmodule

// File: rtl/channel_arbiter_16_rr_pick16.sv
// rr_pick16: rotating-priority search over 16 requests.
// Ports: req_i (16), last_i (4) -> idx_o (4), found_o. Purely combinational.
module rr_pick16 (
   input  logic [15:0] req_i,
   input  logic [3:0]  last_i,
   output logic [3:0]  idx_o,
   output logic        found_o
);

   logic [3:0] cand;

   // Scan from farthest to nearest so the nearest hit after last_i wins.
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      cand    = '0;
      for (int k = 16; k >= 1; k--) begin
         cand = last_i + 4'(k);
         if (req_i[cand]) begin
            idx_o   = cand;
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/channel_arbiter_16.sv
// channel_arbiter_16: round-robin arbiter of 16 valid/ready channels into one
// registered output. Ports: clk, rst, enable, req_valid/req_data/req_ready,
// out_valid/out_ready/out_data/out_sel, busy. Optional xfer_count port when
// CHANNEL_ARBITER_16_XFER_CNT_EN is defined.
module channel_arbiter_16
   import channel_arbiter_16_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic [NUM_CH-1:0]       req_valid,
   input  logic [NUM_CH*WIDTH-1:0] req_data,
   output logic [NUM_CH-1:0]       req_ready,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
`ifdef CHANNEL_ARBITER_16_XFER_CNT_EN
   output logic [15:0]             xfer_count,
`endif
   output logic                    busy
);

   state_e           state_q, state_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [3:0]       sel_q, sel_d;
   logic [3:0]       last_q, last_d;

   logic [3:0]       pick_idx;
   logic             pick_found;
   logic [WIDTH-1:0] pick_data;
   logic             slot_free;
   logic             grant;

   rr_pick16 u_pick (
      .req_i   (req_valid),
      .last_i  (last_q),
      .idx_o   (pick_idx),
      .found_o (pick_found)
   );

   mux16 #(.WIDTH(WIDTH)) u_mux (
      .data_i (req_data),
      .sel_i  (pick_idx),
      .data_o (pick_data)
   );

   assign slot_free = !valid_q || out_ready;
   assign grant     = (state_q == ST_RUN) && slot_free
                      && pick_found && !rst;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (enable) state_d = ST_RUN;
         ST_RUN:   if (!enable) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (enable) state_d = ST_RUN;
            else if (slot_free) state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      valid_d   = valid_q;
      data_d    = data_q;
      sel_d     = sel_q;
      last_d    = last_q;
      if (grant) begin
         req_ready[pick_idx] = 1'b1;
         valid_d = 1'b1;
         data_d  = pick_data;
         sel_d   = pick_idx;
         last_d  = pick_idx;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         data_q  <= '0;
         sel_q   <= '0;
         last_q  <= LAST_GRANT_RST;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
      end
   end

`ifdef CHANNEL_ARBITER_16_XFER_CNT_EN
   logic [15:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else if (valid_q && out_ready) cnt_q <= cnt_q + 16'd1;
   end

   assign xfer_count = cnt_q;
`endif

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_sel   = {{(SEL_W-4){1'b0}}, sel_q};
   assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_channel_arbiter_16.sv
// Self-checking bench for channel_arbiter_16: per-cycle compare against a
// behavioural model plus directed literal expectations.
module tb_channel_arbiter_16;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [15:0]   req_valid;
   logic [16*W-1:0] req_data;
   logic [15:0]   req_ready;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [7:0]    out_sel;
   logic          busy;
`ifdef CHANNEL_ARBITER_16_XFER_CNT_EN
   logic [15:0]   xfer_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   channel_arbiter_16 #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_sel    (out_sel),
`ifdef CHANNEL_ARBITER_16_XFER_CNT_EN
      .xfer_count (xfer_count),
`endif
      .busy       (busy)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 idle, 1 run, 2 drain
   int          m_mode;
   bit          m_v;
   logic [15:0] m_d;
   int          m_sel;
   int          m_last;
   int          m_cnt;
   bit          m_known = 0;
   logic [15:0] exp_rr;
   int          win;
   bit          slot;

   function automatic int pick(input logic [15:0] rv, input int last);
      for (int k = 1; k <= 16; k++) begin
         int c;
         c = (last + k) % 16;
         if (rv[c]) return c;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      #2;
      exp_rr = '0;
      win    = -1;
      slot   = !m_v || out_ready;
      if (m_known && !rst && m_mode == 1 && slot) begin
         win = pick(req_valid, m_last);
         if (win >= 0) exp_rr[win] = 1'b1;
      end
      if (m_known) begin
         chk("m_req_ready", req_ready, exp_rr);
         chk("m_out_valid", out_valid, m_v);
         chk("m_out_data", out_data, m_d);
         chk("m_out_sel", out_sel, m_sel);
         chk("m_busy", busy, m_mode != 0);
`ifdef CHANNEL_ARBITER_16_XFER_CNT_EN
         chk("m_xfer_count", xfer_count, m_cnt);
`endif
      end
      if (rst) begin
         m_known = 1;
         m_mode  = 0;
         m_v     = 0;
         m_d     = '0;
         m_sel   = 0;
         m_last  = 15;
         m_cnt   = 0;
      end else if (m_known) begin
         if (m_v && out_ready) m_cnt = (m_cnt + 1) % 65536;
         if (win >= 0) begin
            m_v    = 1;
            m_d    = req_data[win*16 +: 16];
            m_sel  = win;
            m_last = win;
         end else if (out_ready) begin
            m_v = 0;
         end
         case (m_mode)
            0: if (enable) m_mode = 1;
            1: if (!enable) m_mode = 2;
            default: begin
               if (enable) m_mode = 1;
               else if (slot) m_mode = 0;
            end
         endcase
      end
   end

   // ---------------- stimulus ----------------
   // Inputs change at negedge+1; literal checks happen at negedge+3.
   task automatic cyc(input logic r, input logic e,
                      input logic [15:0] rv, input logic ordy);
      @(negedge clk);
      #1;
      rst       = r;
      enable    = e;
      req_valid = rv;
      out_ready = ordy;
      #2;
   endtask

   logic [15:0] pats [8];

   initial begin
      rst       = 1'b1;
      enable    = 1'b0;
      req_valid = '0;
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) req_data[i*16 +: 16] = 16'hC000 | 16'(i);
      req_data[15:0] = 16'hA5A5;
      pats = '{16'h0000, 16'h0410, 16'h0410, 16'h8000,
               16'h0101, 16'h0101, 16'h0101, 16'hFFFF};

      cyc(1, 0, 16'h0000, 0);
      cyc(1, 0, 16'h0000, 0);
      cyc(0, 0, 16'h0000, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sel", out_sel, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_busy", busy, 0);

      // first grant
      cyc(0, 1, 16'h0000, 1);
      chk("idle_busy", busy, 0);
      cyc(0, 1, 16'h0001, 1);
      chk("g0_req_ready", req_ready, 16'h0001);
      chk("run_busy", busy, 1);
      cyc(0, 1, 16'hFFFF, 1);
      chk("g0_out_valid", out_valid, 1);
      chk("g0_out_data", out_data, 16'hA5A5);
      chk("g0_out_sel", out_sel, 0);

      // full-rate rotation over all channels
      for (int k = 0; k < 18; k++) begin
         cyc(0, 1, 16'hFFFF, 1);
         chk("rot_out_valid", out_valid, 1);
         chk("rot_out_sel", out_sel, (1 + k) % 16);
      end

      // wrap-around between channels 15 and 0
      cyc(1, 0, 16'h0000, 1);
      cyc(0, 1, 16'h0000, 1);
      chk("wr_out_valid", out_valid, 0);
      chk("wr_out_sel", out_sel, 0);
      cyc(0, 1, 16'h8001, 1);
      chk("wr_rr0", req_ready, 16'h0001);
      cyc(0, 1, 16'h8001, 1);
      chk("wr_rr1", req_ready, 16'h8000);
      chk("wr_sel1", out_sel, 0);
      cyc(0, 1, 16'h8001, 1);
      chk("wr_rr2", req_ready, 16'h0001);
      chk("wr_sel2", out_sel, 15);

      // backpressure: held beat, no grants
      for (int k = 0; k < 5; k++) begin
         cyc(0, 1, 16'hFFFF, 0);
         chk("bp_req_ready", req_ready, 16'h0000);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_out_sel", out_sel, 0);
         chk("bp_out_data", out_data, 16'hA5A5);
      end
      cyc(0, 1, 16'hFFFF, 1);
      chk("bp_release_rr", req_ready, 16'h0002);

      // drain with held beat
      cyc(0, 0, 16'hFFFF, 0);
      chk("dr_rr0", req_ready, 16'h0000);
      chk("dr_sel", out_sel, 1);
      cyc(0, 0, 16'hFFFF, 0);
      chk("dr_busy1", busy, 1);
      chk("dr_rr1", req_ready, 16'h0000);
      chk("dr_valid1", out_valid, 1);
      cyc(0, 0, 16'hFFFF, 1);
      chk("dr_busy2", busy, 1);
      chk("dr_rr2", req_ready, 16'h0000);
      cyc(0, 0, 16'hFFFF, 1);
      chk("dr_busy3", busy, 0);
      chk("dr_valid3", out_valid, 0);
      chk("dr_rr3", req_ready, 16'h0000);

      // mixed patterns with intermittent backpressure (model-checked)
      for (int i = 0; i < 16; i++)
         cyc(0, 1, pats[i % 8], (i % 3) != 0);

      // lone requester wins back-to-back
      for (int k = 0; k < 3; k++) begin
         cyc(0, 1, 16'h0040, 1);
         chk("solo_rr", req_ready, 16'h0040);
      end

      // reset mid-stream with a pending beat
      cyc(0, 1, 16'hFFFF, 0);
      cyc(1, 1, 16'hFFFF, 0);
      chk("mrst_rr", req_ready, 16'h0000);
      cyc(0, 1, 16'h0030, 1);
      chk("mrst_out_valid", out_valid, 0);
      chk("mrst_out_sel", out_sel, 0);
      chk("mrst_busy", busy, 0);
`ifdef CHANNEL_ARBITER_16_XFER_CNT_EN
      chk("mrst_xfer", xfer_count, 0);
`endif
      cyc(0, 1, 16'h0030, 1);
      chk("mrst_first_rr", req_ready, 16'h0010);
      cyc(0, 1, 16'h0030, 1);
      chk("mrst_sel", out_sel, 4);
      cyc(0, 1, 16'h0000, 1);
      cyc(0, 0, 16'h0000, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/channel_arbiter_16.md
CHANNEL_ARBITER_16 -- requirements
Module: channel_arbiter_16

Interface
REQ-001 Parameter: WIDTH, default 16, data width of each requester channel and of the output.
REQ-002 Port: clk  input  1  single clock; all logic SHALL be rising-edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: enable  input  1  high grants are permitted; low drains and idles.
REQ-005 Port: req_valid  input  16  bit i high means channel i offers a beat.
REQ-006 Port: req_data  input  16*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port: req_ready  output  16  one-hot or zero; bit i high means channel i's beat is taken this cycle.
REQ-008 Port: out_valid  output  1  output register holds a beat.
REQ-009 Port: out_ready  input  1  downstream accepts the beat when out_valid and out_ready are both high.
REQ-010 Port: out_data  output  WIDTH  registered granted data.
REQ-011 Port: out_sel  output  8  registered index (0..15) of the channel that produced out_data; upper 4 bits always 0.
REQ-012 Port: busy  output  1  high in states RUN and DRAIN.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DRAIN.
- IDLE->RUN when enable=1.
- RUN->DRAIN when enable=0.
- DRAIN->IDLE when the output register is empty or is drained this cycle.
- DRAIN->RUN when enable=1.
REQ-014 The slot is free when out_valid=0 or out_ready=1.
REQ-015 Grant occurs only in RUN, with the slot free and req_valid non-zero.
REQ-016 The winner SHALL be the first set req_valid bit, searching upward from (last_grant+1) mod 16 and wrapping from 15 to 0.
REQ-017 On grant:
- req_ready[winner]=1 combinationally in the same cycle.
- Next edge: out_data=req_data[winner], out_sel=winner, out_valid=1, last_grant=winner.
REQ-018 With no grant:
- req_ready=0.
- If out_ready=1, out_valid clears at the next edge.
- out_data and out_sel SHALL hold their values.
REQ-019 Latency: one cycle from grant to out_valid.
REQ-020 Throughput: one beat per cycle when out_ready is held high.
REQ-021 out_valid=1 with out_ready=0 SHALL hold out_data and out_sel stable and suppress all grants.
REQ-022 A single requesting channel SHALL win on consecutive cycles; last_grant does not block it.
REQ-023 req_ready SHALL never have more than one bit set.
REQ-024 req_ready SHALL be 0 in IDLE and DRAIN.

Reset
REQ-025 On rst=1 at a clock edge, the block SHALL enter the following state regardless of current state or a pending transfer:
- state=IDLE, out_valid=0, out_data=0, out_sel=0, last_grant=15 (so channel 0 has first priority), busy=0.
REQ-026 req_ready SHALL be 0 in any cycle where rst=1.
REQ-027 A beat held in the output register at reset SHALL be discarded.

Configuration
REQ-028 Macro CHANNEL_ARBITER_16_XFER_CNT_EN adds output port xfer_count (16 bits).
REQ-029 xfer_count SHALL increment on every out_valid&&out_ready cycle, wrap from 16'hFFFF to 0, and reset to 0.
REQ-030 Without the macro, the port and counter SHALL be absent, with no other behavioural change.

Structure
REQ-031 A shared package SHALL hold:
- the FSM state encoding;
- constant NUM_CH=16;
- constant SEL_W=8;
- the last_grant reset value 15.
REQ-032 The rotating priority search SHALL be a sub-module rr_pick16: inputs 16-bit request and 4-bit last_grant; outputs 4-bit index and a found flag; purely combinational.
REQ-033 Data selection SHALL reuse the team's existing 16-to-1 multiplexer, driven by the winner index.

Verification
REQ-034 Reset, then enable=1, req_valid=16'h0001, data0=16'hA5A5, out_ready=1 -> req_ready=16'h0001 in the same cycle; next cycle out_valid=1, out_data=16'hA5A5, out_sel=0.
REQ-035 All 16 channels valid continuously, out_ready=1 -> out_sel sequence 0,1,...,15,0,1 on consecutive cycles, with no gaps.
REQ-036 req_valid=16'h8001 with last_grant=15 -> channel 0 wins, then channel 15, then channel 0 (wrap-around check).
REQ-037 out_ready=0 for 5 cycles with a beat held -> req_ready=0 and out_data/out_sel stable throughout; on the out_ready=1 cycle a new grant is issued in the same cycle.
REQ-038 enable dropped while a beat is held with out_ready=0 -> state=DRAIN and busy=1; when out_ready=1 the beat is accepted, the next state is IDLE, and no further req_ready is issued.
REQ-039 rst asserted mid-stream -> next cycle out_valid=0 and out_sel=0; after re-enable the first grant goes to the lowest-indexed valid channel; with the macro defined, xfer_count=0.
